// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ctrl_pkg
//  Description : Shared FSM encoding, channel-index width helper and the
//                saturating duty step used by the PWM ramp sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_ctrl_pkg;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_ramp = 1'b1;

    // Channel select needs at least one bit even for a single channel.
    function automatic int chw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Move duty one step toward target, landing exactly on it; step==0 jumps.
    function automatic logic [31:0] duty_step(input logic [31:0] duty,
                                              input logic [31:0] target,
                                              input logic [31:0] step);
        logic [32:0] w_diff;
        logic [31:0] w_res;
        if (target >= duty) begin
            w_diff = {1'b0, target} - {1'b0, duty};
            if (step == '0 || w_diff <= {1'b0, step})
                w_res = target;
            else
                w_res = duty + step;
        end else begin
            w_diff = {1'b0, duty} - {1'b0, target};
            if (step == '0 || w_diff <= {1'b0, step})
                w_res = target;
            else
                w_res = duty - step;
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_chan.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_chan
//  Description : One PWM channel: config shadow, IDLE/RAMP engine, rate
//                divider, duty register and registered compare output.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_ramp_chan import pwm_ctrl_pkg::*; #(
    parameter int DW = 8,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_cnt,
    input  logic          i_boundary,
    input  logic          i_wr,
    input  logic [DW-1:0] i_target,
    input  logic [DW-1:0] i_step,
    input  logic [RW-1:0] i_rate,
    output logic          o_pending,
    output logic          o_pwm,
    output logic          o_busy,
    output logic          o_done
);

    logic          r_pending;
    logic [DW-1:0] r_sh_target;
    logic [DW-1:0] r_sh_step;
    logic [RW-1:0] r_sh_rate;
    logic [0:0]    r_state;
    logic [DW-1:0] r_target;
    logic [DW-1:0] r_step;
    logic [RW-1:0] r_rate;
    logic [RW-1:0] r_rate_cnt;
    logic [DW-1:0] r_duty;
    logic          r_pwm;
    logic          r_done;

    logic [RW-1:0] w_rate_eff;
    logic [RW-1:0] w_rc_inc;
    logic          w_step_due;
    logic [DW-1:0] w_next_duty;

    assign w_rate_eff  = (r_rate == '0) ? RW'(1) : r_rate;
    assign w_rc_inc    = r_rate_cnt + 1'b1;
    assign w_step_due  = (w_rc_inc >= w_rate_eff);
    assign w_next_duty = DW'(duty_step(32'(r_duty), 32'(r_target), 32'(r_step)));

    // Boundary is the edge entering cnt==0, so a new duty owns the whole period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= 1'b0;
            r_sh_target <= '0;
            r_sh_step   <= '0;
            r_sh_rate   <= '0;
            r_state     <= c_st_idle;
            r_target    <= '0;
            r_step      <= '0;
            r_rate      <= '0;
            r_rate_cnt  <= '0;
            r_duty      <= '0;
            r_pwm       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_pwm  <= (r_duty > i_cnt);
            if (i_boundary) begin
                if (r_pending) begin
                    r_pending  <= 1'b0;
                    r_target   <= r_sh_target;
                    r_step     <= r_sh_step;
                    r_rate     <= r_sh_rate;
                    r_rate_cnt <= '0;
                    if (r_sh_target != r_duty) begin
                        r_state <= c_st_ramp;
                    end else begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                    end
                end else if (r_state == c_st_ramp) begin
                    if (w_step_due) begin
                        r_duty     <= w_next_duty;
                        r_rate_cnt <= '0;
                        if (w_next_duty == r_target) begin
                            r_done  <= 1'b1;
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_rate_cnt <= w_rc_inc;
                    end
                end
            end
            if (i_wr) begin
                r_pending   <= 1'b1;
                r_sh_target <= i_target;
                r_sh_step   <= i_step;
                r_sh_rate   <= i_rate;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_pwm     = r_pwm;
    assign o_busy    = r_pending | (r_state == c_st_ramp);
    assign o_done    = r_done;

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_ctrl
//  Description : Multi-channel PWM sequencer: shared period counter, host
//                write decode and CH ramping compare channels.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_ramp_ctrl import pwm_ctrl_pkg::*; #(
    parameter int CH = 4,
    parameter int DW = 8,
    parameter int RW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [chw_of(CH)-1:0] cfg_ch,
    input  logic [DW-1:0]         cfg_target,
    input  logic [DW-1:0]         cfg_step,
    input  logic [RW-1:0]         cfg_rate,
    output logic [CH-1:0]         pwm_out,
    output logic [CH-1:0]         ramp_busy,
    output logic [CH-1:0]         ramp_done,
    output logic                  period_start
);

    localparam int            CHW       = chw_of(CH);
    localparam int            c_pend_w  = 2**CHW;
    localparam logic [DW-1:0] c_cnt_max = '1;

    logic [DW-1:0]       r_cnt;
    logic                r_period_start;
    logic                w_boundary;
    logic                w_accept;
    logic [CH-1:0]       w_pending;
    logic [c_pend_w-1:0] w_pend_pad;

    assign w_boundary = (r_cnt == c_cnt_max);

    // period_start is registered so it stays low in the post-reset cnt==0 slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + 1'b1;
            r_period_start <= w_boundary;
        end
    end

    assign period_start = r_period_start;

    // Unused channel codes read as ready and are silently dropped.
    generate
        if (c_pend_w == CH) begin : g_pend_full
            assign w_pend_pad = w_pending;
        end else begin : g_pend_pad
            assign w_pend_pad = {{(c_pend_w - CH){1'b0}}, w_pending};
        end
    endgenerate

    assign cfg_ready = ~w_pend_pad[cfg_ch];
    assign w_accept  = cfg_valid & cfg_ready;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_chan
            pwm_ramp_chan #(
                .DW (DW),
                .RW (RW)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_cnt      (r_cnt),
                .i_boundary (w_boundary),
                .i_wr       (w_accept && (cfg_ch == CHW'(i))),
                .i_target   (cfg_target),
                .i_step     (cfg_step),
                .i_rate     (cfg_rate),
                .o_pending  (w_pending[i]),
                .o_pwm      (pwm_out[i]),
                .o_busy     (ramp_busy[i]),
                .o_done     (ramp_done[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_ramp_ctrl
//  Description : Directed self-checking bench; duty is recovered by counting
//                pwm_out high cycles over each 256-clock period.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_target = '0;
    logic [7:0] cfg_step = '0;
    logic [7:0] cfg_rate = '0;
    logic [3:0] pwm_out;
    logic [3:0] ramp_busy;
    logic [3:0] ramp_done;
    logic       period_start;

    int n_cmp = 0;
    int n_fail = 0;
    int acc[4];
    int meas[4];
    logic [3:0] ps_done, ps_busy, ps_pwm;
    logic       wr_ps;
    logic [3:0] wr_busy, wr_done;

    pwm_ramp_ctrl #(.CH(4), .DW(8), .RW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_target   (cfg_target),
        .cfg_step     (cfg_step),
        .cfg_rate     (cfg_rate),
        .pwm_out      (pwm_out),
        .ramp_busy    (ramp_busy),
        .ramp_done    (ramp_done),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    // High-cycle count of the window that closes with each period_start cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) acc[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) acc[i] += int'(pwm_out[i]);
            if (period_start) begin
                meas = acc;
                for (int i = 0; i < 4; i++) acc[i] = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps;
        int n = 0;
        while (period_start !== 1'b1 && n < 300) begin
            tick;
            n++;
        end
        n_cmp++;
        if (period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ps: period_start=%b after %0d clk, required 1", period_start, n);
        end
        ps_done = ramp_done;
        ps_busy = ramp_busy;
        ps_pwm  = pwm_out;
    endtask

    task automatic next_ps;
        wait_ps;
        tick;
        n_cmp++;
        if (period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL ps_width: period_start=%b one clk later, required 0", period_start);
        end
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [7:0] tgt,
                            input logic [7:0] stp, input logic [7:0] rt, output int waits);
        cfg_ch = ch; cfg_target = tgt; cfg_step = stp; cfg_rate = rt; cfg_valid = 1'b1;
        #1;
        waits = 0;
        while (cfg_ready !== 1'b1 && waits < 600) begin
            tick;
            waits++;
        end
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ready ch%0d: cfg_ready=%b after %0d clk, required 1", ch, cfg_ready, waits);
        end
        wr_ps = period_start; wr_busy = ramp_busy; wr_done = ramp_done;
        tick;
        cfg_valid = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        n_cmp++;
        if (pwm_out !== 4'b0 || ramp_busy !== 4'b0 || ramp_done !== 4'b0 ||
            period_start !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: pwm=%b busy=%b done=%b ps=%b ready=%b, required 0000 0000 0000 0 1",
                     tag, pwm_out, ramp_busy, ramp_done, period_start, cfg_ready);
        end
    endtask

    task automatic count_to_first_ps(input string tag);
        int n = 0;
        while (period_start !== 1'b1 && n < 400) begin
            tick;
            n++;
        end
        n_cmp++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL %s: first period_start after %0d clk, required 256", tag, n);
        end
    endtask

    task automatic test_reset;
        repeat (3) tick;
        cfg_ch = 2'd0; #1;
        chk_idle_outputs("reset_ch0");
        cfg_ch = 2'd3; #1;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_ch3: cfg_ready=%b, required 1", cfg_ready);
        end
        rst_n = 1'b1;
        count_to_first_ps("reset_release");
        tick;
    endtask

    task automatic test_jump;
        int w;
        do_write(2'd0, 8'd128, 8'd0, 8'd1, w);
        n_cmp++;
        if (ramp_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_pending: busy[0]=%b, required 1", ramp_busy[0]);
        end
        for (int k = 0; k < 4; k++) begin
            next_ps;
            n_cmp++;
            if (ps_done[0] !== (k == 1) || ps_busy[0] !== (k == 0) ||
                meas[0] != ((k >= 2) ? 128 : 0)) begin
                n_fail++;
                $display("FAIL jump k=%0d: done=%b busy=%b duty=%0d, required %b %b %0d",
                         k, ps_done[0], ps_busy[0], meas[0], k == 1, k == 0, (k >= 2) ? 128 : 0);
            end
        end
    endtask

    task automatic test_ramp_up;
        int w;
        int exp_d[10] = '{0, 0, 0, 30, 30, 60, 60, 90, 90, 100};
        do_write(2'd1, 8'd100, 8'd30, 8'd2, w);
        for (int k = 0; k < 10; k++) begin
            next_ps;
            n_cmp++;
            if (ps_done[1] !== (k == 8) || ps_busy[1] !== (k < 8) ||
                meas[1] != exp_d[k] || meas[0] != 128) begin
                n_fail++;
                $display("FAIL ramp_up k=%0d: done=%b busy=%b duty1=%0d duty0=%0d, required %b %b %0d 128",
                         k, ps_done[1], ps_busy[1], meas[1], meas[0], k == 8, k < 8, exp_d[k]);
            end
        end
    endtask

    task automatic test_ramp_down;
        int w;
        int exp_d[6] = '{100, 100, 60, 20, 0, 0};
        do_write(2'd2, 8'd100, 8'd0, 8'd1, w);
        next_ps;
        next_ps;
        n_cmp++;
        if (ps_done[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL down_preset: done[2]=%b, required 1", ps_done[2]);
        end
        do_write(2'd2, 8'd0, 8'd40, 8'd1, w);
        for (int k = 0; k < 6; k++) begin
            next_ps;
            n_cmp++;
            if (ps_done[2] !== (k == 3) || ps_busy[2] !== (k < 3) || meas[2] != exp_d[k] ||
                (k >= 4 && ps_pwm[2] !== 1'b0)) begin
                n_fail++;
                $display("FAIL ramp_down k=%0d: done=%b busy=%b duty=%0d pwm=%b, required %b %b %0d",
                         k, ps_done[2], ps_busy[2], meas[2], ps_pwm[2], k == 3, k < 3, exp_d[k]);
            end
        end
    endtask

    task automatic test_full_duty;
        int w;
        int exp0[4] = '{128, 128, 255, 255};
        int exp1[4] = '{100, 50, 0, 0};
        do_write(2'd1, 8'd0, 8'd50, 8'd1, w);
        wait_ps;
        do_write(2'd0, 8'd255, 8'd0, 8'd1, w);
        n_cmp++;
        if (wr_ps !== 1'b1 || w != 0) begin
            n_fail++;
            $display("FAIL ps_write: accepted with ps=%b after %0d waits, required ps=1 waits=0", wr_ps, w);
        end
        for (int k = 0; k < 4; k++) begin
            next_ps;
            n_cmp++;
            if (meas[0] != exp0[k] || meas[1] != exp1[k] || ps_done[0] !== (k == 1) ||
                ps_done[1] !== (k == 1) || ps_busy[0] !== (k == 0) || ps_pwm[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL full_duty k=%0d: duty0=%0d duty1=%0d done=%b busy=%b pwm_ps=%b, required %0d %0d done01=%b busy0=%b pwm0=0",
                         k, meas[0], meas[1], ps_done, ps_busy, ps_pwm, exp0[k], exp1[k], k == 1, k == 0);
            end
        end
        n_cmp++;
        if (pwm_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_duty_slot1: pwm[0]=%b after period_start, required 1", pwm_out[0]);
        end
    endtask

    task automatic test_back_to_back;
        int w;
        int exp_d[8] = '{0, 0, 20, 20, 40, 60, 80, 100};
        do_write(2'd3, 8'd200, 8'd20, 8'd1, w);
        do_write(2'd3, 8'd60, 8'd20, 8'd1, w);
        n_cmp++;
        if (w == 0 || wr_ps !== 1'b1 || wr_busy[3] !== 1'b1 || wr_done[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: waits=%0d ps=%b busy3=%b done3=%b, required waits>0 ps=1 busy3=1 done3=0",
                     w, wr_ps, wr_busy[3], wr_done[3]);
        end
        for (int k = 1; k <= 8; k++) begin
            next_ps;
            n_cmp++;
            if (ps_done[3] !== (k == 7) || ps_busy[3] !== (k < 7) || meas[3] != exp_d[k-1]) begin
                n_fail++;
                $display("FAIL b2b k=%0d: done=%b busy=%b duty=%0d, required %b %b %0d",
                         k, ps_done[3], ps_busy[3], meas[3], k == 7, k < 7, exp_d[k-1]);
            end
            if (k == 2) do_write(2'd3, 8'd100, 8'd20, 8'd1, w);
        end
    endtask

    task automatic test_reset_mid_ramp;
        int w;
        do_write(2'd1, 8'd200, 8'd10, 8'd1, w);
        next_ps;
        next_ps;
        repeat (10) tick;
        cfg_ch = 2'd1;
        n_cmp++;
        if (pwm_out[0] !== 1'b1 || ramp_busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: pwm0=%b busy1=%b, required 1 1", pwm_out[0], ramp_busy[1]);
        end
        rst_n = 1'b0;
        #2;
        chk_idle_outputs("async_reset");
        tick;
        tick;
        rst_n = 1'b1;
        count_to_first_ps("restart");
        n_cmp++;
        if (ramp_done !== 4'b0 || ramp_busy !== 4'b0) begin
            n_fail++;
            $display("FAIL restart_ps: done=%b busy=%b, required 0000 0000", ramp_done, ramp_busy);
        end
        tick;
        next_ps;
        n_cmp++;
        if (meas[0] != 0 || meas[1] != 0 || meas[2] != 0 || meas[3] != 0) begin
            n_fail++;
            $display("FAIL restart_duty: %0d %0d %0d %0d, required all 0", meas[0], meas[1], meas[2], meas[3]);
        end
    endtask

    initial begin
        test_reset;
        test_jump;
        test_ramp_up;
        test_ramp_down;
        test_full_duty;
        test_back_to_back;
        test_reset_mid_ramp;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
